// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu loader: FSM state codes, memory strides and
// the byte-address helper used for both memories.
package cpu_loader_pkg;

   localparam int ADDR_W      = 64;
   localparam int IMEM_STRIDE = 4;
   localparam int DMEM_STRIDE = 8;
   localparam int STATE_W     = 4;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_LOAD_I    = 4'd1;
   localparam state_t ST_LOAD_D_LO = 4'd2;
   localparam state_t ST_LOAD_D_HI = 4'd3;
   // One-cycle gap so the last data-memory write retires before the cpu runs.
   localparam state_t ST_LOAD_END  = 4'd4;
   localparam state_t ST_RUN       = 4'd5;
   localparam state_t ST_DUMP_REQ  = 4'd6;
   localparam state_t ST_DUMP_CAP  = 4'd7;
   localparam state_t ST_DUMP_OUT  = 4'd8;
   localparam state_t ST_DONE      = 4'd9;

   function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] index,
                                                   input logic [ADDR_W-1:0] stride);
      return index * stride;
   endfunction

endpackage

// File: rtl/cpu_loader.sv
// Host-side loader: streams the program and data images into the cpu memories,
// runs the cpu for a fixed budget, then dumps a window of data memory.
module cpu_loader
   import cpu_loader_pkg::*;
#(
   parameter int IMEM_WORDS = 128,
   parameter int DMEM_WORDS = 64,
   parameter int RUN_CYCLES = 1024,
   parameter int DUMP_WORDS = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [63:0]       out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              cpu_enable,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   output logic [ADDR_W-1:0] addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [63:0]       wdata_ext_2,
   input  logic [63:0]       rdata_ext_2
);

   localparam int I_W = $clog2(IMEM_WORDS + 1);
   localparam int D_W = $clog2(DMEM_WORDS + 1);
   localparam int R_W = $clog2(RUN_CYCLES + 1);
   localparam int K_W = $clog2(DUMP_WORDS + 1);

   state_t         state;
   logic [I_W-1:0] i_cnt;
   logic [D_W-1:0] j_cnt;
   logic [R_W-1:0] run_cnt;
   logic [K_W-1:0] k_cnt;
   logic [31:0]    low_half;

   logic in_hs;
   logic out_hs;
   logic i_last;
   logic j_last;
   logic run_last;
   logic k_last;

   assign in_ready   = (state == ST_LOAD_I) || (state == ST_LOAD_D_LO) ||
                       (state == ST_LOAD_D_HI);
   assign in_hs      = in_valid && in_ready;
   assign out_hs     = out_valid && out_ready && (state == ST_DUMP_OUT);

   assign i_last     = (i_cnt   == I_W'(IMEM_WORDS - 1));
   assign j_last     = (j_cnt   == D_W'(DMEM_WORDS - 1));
   assign run_last   = (run_cnt == R_W'(RUN_CYCLES - 1));
   assign k_last     = (k_cnt   == K_W'(DUMP_WORDS - 1));

   // Decoded straight from the state register so reset drops them immediately.
   assign busy       = (state != ST_IDLE) && (state != ST_DONE);
   assign done       = (state == ST_DONE);
   assign cpu_enable = (state == ST_RUN);
   assign ren_ext_2  = (state == ST_DUMP_REQ);
   assign ren_ext    = 1'b0;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= ST_IDLE;
         i_cnt   <= '0;
         j_cnt   <= '0;
         run_cnt <= '0;
         k_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_LOAD_I;
                  i_cnt   <= '0;
                  j_cnt   <= '0;
                  run_cnt <= '0;
                  k_cnt   <= '0;
               end
            end
            ST_LOAD_I: begin
               if (in_hs) begin
                  if (i_last) state <= ST_LOAD_D_LO;
                  else        i_cnt <= i_cnt + I_W'(1);
               end
            end
            ST_LOAD_D_LO: begin
               if (in_hs) state <= ST_LOAD_D_HI;
            end
            ST_LOAD_D_HI: begin
               if (in_hs) begin
                  if (j_last) begin
                     state <= ST_LOAD_END;
                  end else begin
                     j_cnt <= j_cnt + D_W'(1);
                     state <= ST_LOAD_D_LO;
                  end
               end
            end
            ST_LOAD_END: state <= ST_RUN;
            ST_RUN: begin
               if (run_last) state   <= ST_DUMP_REQ;
               else          run_cnt <= run_cnt + R_W'(1);
            end
            ST_DUMP_REQ: state <= ST_DUMP_CAP;
            ST_DUMP_CAP: state <= ST_DUMP_OUT;
            ST_DUMP_OUT: begin
               if (out_hs) begin
                  if (k_last) begin
                     state <= ST_DONE;
                  end else begin
                     k_cnt <= k_cnt + K_W'(1);
                     state <= ST_DUMP_REQ;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         addr_ext  <= '0;
         wdata_ext <= '0;
         wen_ext   <= 1'b0;
      end else begin
         wen_ext <= (state == ST_LOAD_I) && in_hs;
         if ((state == ST_LOAD_I) && in_hs) begin
            addr_ext  <= byte_addr(ADDR_W'(i_cnt), ADDR_W'(IMEM_STRIDE));
            wdata_ext <= in_data;
         end
      end
   end

   // Data-memory port is shared by the load writes and the dump reads.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         low_half    <= '0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
         wen_ext_2   <= 1'b0;
      end else begin
         wen_ext_2 <= (state == ST_LOAD_D_HI) && in_hs;
         if ((state == ST_LOAD_D_LO) && in_hs) begin
            low_half <= in_data;
         end
         if ((state == ST_LOAD_D_HI) && in_hs) begin
            wdata_ext_2 <= {in_data, low_half};
            addr_ext_2  <= byte_addr(ADDR_W'(j_cnt), ADDR_W'(DMEM_STRIDE));
         end else if ((state == ST_RUN) && run_last) begin
            addr_ext_2  <= '0;
         end else if (out_hs && !k_last) begin
            addr_ext_2  <= byte_addr(ADDR_W'(k_cnt) + ADDR_W'(1), ADDR_W'(DMEM_STRIDE));
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (state == ST_DUMP_CAP) begin
            out_data  <= rdata_ext_2;
            out_valid <= 1'b1;
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: drives load/run/dump sequences against a small memory
// and cpu model, and compares the write trace and dump against the images.
module tb_cpu_loader;

   localparam int IMEM_WORDS = 4;
   localparam int DMEM_WORDS = 2;
   localparam int RUN_CYCLES = 8;
   localparam int DUMP_WORDS = 2;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        cpu_enable;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2 = '0;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   logic   cpu_patch = 1'b0;
   int     excl_bad = 0;
   int     run_ready_bad = 0;
   logic   ov_prev = 1'b0;

   logic [63:0] mem [0:7];
   logic [31:0] dir_img [IMEM_WORDS] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
   logic [31:0] dir_dat [2*DMEM_WORDS] = '{32'h1, 32'h2, 32'h3, 32'h4};

   typedef struct {
      longint      cyc;
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t    imem_log [$];
   wr_t    dmem_log [$];
   longint en_log [$];
   longint ov_log [$];

   cpu_loader #(
      .IMEM_WORDS(IMEM_WORDS),
      .DMEM_WORDS(DMEM_WORDS),
      .RUN_CYCLES(RUN_CYCLES),
      .DUMP_WORDS(DUMP_WORDS)
   ) dut (
      .clk(clk), .arst_n(arst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory with one-cycle read latency; the cpu model rewrites two words while enabled.
   always @(posedge clk) begin
      if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[5:3]];
      if (wen_ext_2) mem[addr_ext_2[5:3]] <= wdata_ext_2;
      if (cpu_enable && cpu_patch) begin
         mem[0] <= 64'hDEADBEEF00000000;
         mem[1] <= 64'h0000000000000005;
      end
   end

   always @(negedge clk) begin
      if (arst_n) begin
         if (wen_ext)   imem_log.push_back('{cyc, addr_ext, {32'h0, wdata_ext}});
         if (wen_ext_2) dmem_log.push_back('{cyc, addr_ext_2, wdata_ext_2});
         if (cpu_enable) en_log.push_back(cyc);
         if (out_valid && !ov_prev) ov_log.push_back(cyc);
         if ((int'(wen_ext) + int'(wen_ext_2) + int'(ren_ext_2)) > 1 || ren_ext) excl_bad++;
         if (cpu_enable && in_ready) run_ready_bad++;
      end
      ov_prev = out_valid;
   end

   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input int gap, input bit poke_start, output longint hs);
      bit ok;
      ok = 1'b0;
      hs = 0;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            hs = cyc;
            ok = 1'b1;
            break;
         end
      end
      check_output("in_ready_wait", 64'(ok), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic check_loads(input int ib, input int db, input logic [31:0] ibeats [IMEM_WORDS],
                              input logic [31:0] dbeats [2*DMEM_WORDS],
                              input longint ihs [IMEM_WORDS], input longint dhs [DMEM_WORDS]);
      check_output("imem_count", 64'(imem_log.size() - ib), 64'(IMEM_WORDS));
      for (int i = 0; i < IMEM_WORDS && ib + i < imem_log.size(); i++) begin
         check_output("imem_addr", imem_log[ib+i].addr, 64'(i * 4));
         check_output("imem_data", imem_log[ib+i].data, {32'h0, ibeats[i]});
         check_output("imem_cycle", 64'(imem_log[ib+i].cyc), 64'(ihs[i] + 1));
      end
      check_output("dmem_count", 64'(dmem_log.size() - db), 64'(DMEM_WORDS));
      for (int j = 0; j < DMEM_WORDS && db + j < dmem_log.size(); j++) begin
         check_output("dmem_addr", dmem_log[db+j].addr, 64'(j * 8));
         check_output("dmem_data", dmem_log[db+j].data, {dbeats[2*j+1], dbeats[2*j]});
         check_output("dmem_cycle", 64'(dmem_log[db+j].cyc), 64'(dhs[j] + 1));
      end
   endtask

   task automatic apply_stimulus(input bit directed, input bit abort_in_run);
      logic [31:0] ibeats [IMEM_WORDS];
      logic [31:0] dbeats [2*DMEM_WORDS];
      logic [63:0] exp_dump [DUMP_WORDS];
      longint      ihs [IMEM_WORDS];
      longint      dhs [DMEM_WORDS];
      longint      hs;
      int          ib, db, eb, ob, stall, n;
      bit          ok;

      ib = imem_log.size();
      db = dmem_log.size();
      eb = en_log.size();
      ob = ov_log.size();
      cpu_patch = directed;
      for (int i = 0; i < IMEM_WORDS; i++) ibeats[i] = directed ? dir_img[i] : $urandom;
      for (int i = 0; i < 2*DMEM_WORDS; i++) dbeats[i] = directed ? dir_dat[i] : $urandom;
      for (int k = 0; k < DUMP_WORDS; k++) begin
         if (directed) exp_dump[k] = (k == 0) ? 64'hDEADBEEF00000000 : 64'h5;
         else          exp_dump[k] = {dbeats[2*k+1], dbeats[2*k]};
      end

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_output("busy_after_start", 64'(busy), 64'd1);

      for (int i = 0; i < IMEM_WORDS; i++) begin
         send_beat(ibeats[i], directed ? 0 : $urandom_range(0, 5), !directed, hs);
         ihs[i] = hs;
      end
      for (int j = 0; j < DMEM_WORDS; j++) begin
         send_beat(dbeats[2*j], directed ? 0 : $urandom_range(0, 5), !directed, hs);
         send_beat(dbeats[2*j+1], directed ? 0 : $urandom_range(0, 5), !directed, hs);
         dhs[j] = hs;
      end
      // Keep offering junk: the loader must not consume anything past the image.
      in_valid = 1'b1;
      in_data  = 32'hBAD0BAD0;

      if (abort_in_run) begin
         ok = 1'b0;
         for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (en_log.size() - eb >= 3) begin
               ok = 1'b1;
               break;
            end
         end
         check_output("run_reached", 64'(ok), 64'd1);
         arst_n = 1'b0;
         #1;
         check_output("abort_cpu_enable", 64'(cpu_enable), 64'd0);
         check_output("abort_busy", 64'(busy), 64'd0);
         check_output("abort_done", 64'(done), 64'd0);
         check_output("abort_in_ready", 64'(in_ready), 64'd0);
         in_valid = 1'b0;
         check_loads(ib, db, ibeats, dbeats, ihs, dhs);
         @(posedge clk); #1;
         @(posedge clk); #1;
         arst_n = 1'b1;
         @(posedge clk); #1;
         check_output("idle_after_abort", 64'({busy, done}), 64'd0);
         return;
      end

      for (int k = 0; k < DUMP_WORDS; k++) begin
         ok = 1'b0;
         for (int t = 0; t < RUN_CYCLES + 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
               ok = 1'b1;
               break;
            end
         end
         check_output("out_valid_wait", 64'(ok), 64'd1);
         if (ok) begin
            check_output("dump_data", out_data, exp_dump[k]);
            stall = directed ? 3 : $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               check_output("hold_valid", 64'(out_valid), 64'd1);
               check_output("hold_data", out_data, exp_dump[k]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_output("valid_drop", 64'(out_valid), 64'd0);
         end
      end

      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check_output("done_set", 64'(ok), 64'd1);
      check_output("busy_clear", 64'(busy), 64'd0);
      in_valid = 1'b0;

      check_loads(ib, db, ibeats, dbeats, ihs, dhs);
      n = en_log.size() - eb;
      check_output("run_length", 64'(n), 64'(RUN_CYCLES));
      if (n > 0) begin
         check_output("run_first", 64'(en_log[eb]), 64'(dhs[DMEM_WORDS-1] + 2));
         check_output("run_contig", 64'(en_log[en_log.size()-1] - en_log[eb]), 64'(RUN_CYCLES - 1));
         if (ov_log.size() > ob)
            check_output("dump_latency", 64'(ov_log[ob]), 64'(en_log[en_log.size()-1] + 3));
      end
      check_output("strobe_excl", 64'(excl_bad), 64'd0);
      check_output("run_in_ready", 64'(run_ready_bad), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      arst_n    = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd0);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_cpu_enable", 64'(cpu_enable), 64'd0);
      check_output("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
      check_output("rst_addr", addr_ext | addr_ext_2, 64'd0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
      check_output("idle_busy", 64'(busy), 64'd0);

      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
